// File: rtl/cpu_debug_scan_pkg.sv
// Shared types and constants for the CPU debug virtual-JTAG scan master.
package cpu_debug_scan_pkg;

  localparam int unsigned DR_WIDTH_DEF = 38;
  localparam int unsigned IR_WIDTH_DEF = 2;

  // Virtual TAP walk performed for every command
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UIR  = 3'd1,
    CDR  = 3'd2,
    SDR  = 3'd3,
    UDR  = 3'd4,
    RSP  = 3'd5
  } scan_state_e;

  // Virtual IR codes understood by the debug slave
  localparam logic [IR_WIDTH_DEF-1:0] IR_OCIMEM   = 2'd0;
  localparam logic [IR_WIDTH_DEF-1:0] IR_TRACEMEM = 2'd1;
  localparam logic [IR_WIDTH_DEF-1:0] IR_BREAK    = 2'd2;
  localparam logic [IR_WIDTH_DEF-1:0] IR_ENABLE   = 2'd3;

endpackage

// File: rtl/cpu_debug_scan_tckgen.sv
// Free-running test-clock divider: tck low for TCK_DIV clks, high for TCK_DIV clks,
// with single-cycle strobes marking the clk edge on which tck rises or falls.
module cpu_debug_scan_tckgen #(
  parameter int unsigned TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic tck,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned CW = (2 * TCK_DIV > 1) ? $clog2(2 * TCK_DIV) : 1;

  logic [CW-1:0] cnt;

  // Strobes are decoded from the phase counter so they align with the tck update
  assign rise_c = (cnt == CW'(TCK_DIV - 1));
  assign fall_c = (cnt == CW'(2 * TCK_DIV - 1));

  // Phase counter and tck register; reset restarts the clock low
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
      tck <= 1'b0;
    end else begin
      cnt <= fall_c ? '0 : cnt + CW'(1);
      if (rise_c) tck <= 1'b1;
      else if (fall_c) tck <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_debug_scan_master.sv
// Initiator side of the CPU debug virtual-JTAG link: turns one {IR, DR} command
// into UIR, CDR, SDR x DR_WIDTH, UDR and returns the captured DR word.
// Optional build macro DEBUG_SCAN_IR_CACHE_EN skips UIR when the IR is unchanged.
module cpu_debug_scan_master
  import cpu_debug_scan_pkg::*;
#(
  parameter int unsigned DR_WIDTH = DR_WIDTH_DEF,
  parameter int unsigned IR_WIDTH = IR_WIDTH_DEF,
  parameter int unsigned TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_rti,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr
);

  localparam int unsigned CNT_W = $clog2(DR_WIDTH + 1);

  scan_state_e         state, state_nxt;
  logic                rise_c, fall_c;
  logic                accept_c, skip_uir_c;
  logic                pend, pend_nxt;
  logic [IR_WIDTH-1:0] ir_lat;
  logic [DR_WIDTH-1:0] shift;
  logic [CNT_W-1:0]    bit_cnt;
  logic                cmd_ready_d, rti_d, uir_d, cdr_d, sdr_d, udr_d, tdi_d;
`ifdef DEBUG_SCAN_IR_CACHE_EN
  logic                ir_valid;
`endif

  // Test clock and its rise/fall strobes
  cpu_debug_scan_tckgen #(
    .TCK_DIV (TCK_DIV)
  ) u_tckgen (
    .clk     (clk),
    .reset_n (reset_n),
    .tck     (vji_tck),
    .rise_c  (rise_c),
    .fall_c  (fall_c)
  );

  // Next state and next values of the registered TAP strobes
  always_comb begin
    state_nxt  = state;
    accept_c   = cmd_valid && cmd_ready;
    skip_uir_c = 1'b0;
`ifdef DEBUG_SCAN_IR_CACHE_EN
    skip_uir_c = ir_valid && (ir_lat == vji_ir_in);
`endif
    case (state)
      IDLE:    if (pend && fall_c) state_nxt = skip_uir_c ? CDR : UIR;
      UIR:     if (fall_c) state_nxt = CDR;
      CDR:     if (fall_c) state_nxt = SDR;
      SDR:     if (fall_c && (bit_cnt == CNT_W'(DR_WIDTH))) state_nxt = UDR;
      UDR:     if (fall_c) state_nxt = RSP;
      RSP:     if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A latched command waits in IDLE until the next fall strobe
    pend_nxt    = accept_c || (pend && (state_nxt == IDLE));
    cmd_ready_d = (state_nxt == IDLE) && !pend_nxt;
    // RSP keeps rti high so the handshake exit needs no strobe-time change
    rti_d       = (state_nxt == IDLE) || (state_nxt == RSP);
    uir_d       = (state_nxt == UIR);
    cdr_d       = (state_nxt == CDR);
    sdr_d       = (state_nxt == SDR);
    udr_d       = (state_nxt == UDR);
    tdi_d       = (state_nxt == SDR) ? shift[0] : 1'b0;
  end

  // State, handshake and TAP output registers; TAP outputs move only on fall strobes
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      pend      <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      vji_rti   <= 1'b1;
      vji_uir   <= 1'b0;
      vji_cdr   <= 1'b0;
      vji_sdr   <= 1'b0;
      vji_udr   <= 1'b0;
      vji_tdi   <= 1'b0;
      vji_ir_in <= '0;
    end else begin
      state     <= state_nxt;
      pend      <= pend_nxt;
      cmd_ready <= cmd_ready_d;
      rsp_valid <= (state_nxt == RSP);
      if (fall_c) begin
        vji_rti <= rti_d;
        vji_uir <= uir_d;
        vji_cdr <= cdr_d;
        vji_sdr <= sdr_d;
        vji_udr <= udr_d;
        vji_tdi <= tdi_d;
        if (state_nxt == UIR) vji_ir_in <= ir_lat;
      end
    end
  end

  // Command latch, DR shift register, bit counter and response capture
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ir_lat     <= '0;
      shift      <= '0;
      bit_cnt    <= '0;
      rsp_data   <= '0;
      rsp_ir_out <= '0;
`ifdef DEBUG_SCAN_IR_CACHE_EN
      ir_valid   <= 1'b0;
`endif
    end else begin
      if (accept_c) begin
        ir_lat  <= cmd_ir;
        shift   <= cmd_data;
        bit_cnt <= '0;
      end else if ((state == SDR) && rise_c) begin
        shift   <= {vji_tdo, shift[DR_WIDTH-1:1]};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if ((state == UDR) && rise_c) rsp_ir_out <= vji_ir_out;
      if ((state == UDR) && fall_c) rsp_data <= shift;
`ifdef DEBUG_SCAN_IR_CACHE_EN
      if ((state == UIR) && fall_c) ir_valid <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_cpu_debug_scan_master.sv
// Scoreboard bench for cpu_debug_scan_master: unit 0 uses TCK_DIV=2, unit 1 TCK_DIV=1,
// each scanning against a behavioural virtual-JTAG slave.
`timescale 1ns/1ps
module tb_cpu_debug_scan_master;
  import cpu_debug_scan_pkg::*;

  localparam int unsigned DW = 38;
  localparam int unsigned IW = 2;
`ifdef DEBUG_SCAN_IR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  typedef struct {
    int          unit;
    logic [DW-1:0] data;
    logic [IW-1:0] ir_out;
    logic [DW-1:0] rx;
    int          lat_min;
    int          lat_max;
    int          uir_n;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]    reset_n   = 2'b00;
  logic [1:0]    cmd_valid = 2'b00;
  logic [1:0]    rsp_ready = 2'b11;
  logic [IW-1:0] cmd_ir   [2];
  logic [DW-1:0] cmd_data [2];
  logic [DW-1:0] slv_cap  [2];
  wire  [1:0]    cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_tdo;
  wire  [1:0]    vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr;
  wire  [DW-1:0] rsp_data   [2];
  wire  [IW-1:0] rsp_ir_out [2];
  wire  [IW-1:0] vji_ir_in  [2];
  wire  [IW-1:0] vji_ir_out [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s bound expired or unexpected event", name);
  endtask

  function automatic int find_exp(input int u);
    foreach (exp_q[i]) if (exp_q[i].unit == u) return i;
    return -1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_u
    cpu_debug_scan_master #(
      .DR_WIDTH (DW),
      .IR_WIDTH (IW),
      .TCK_DIV  ((g == 0) ? 2 : 1)
    ) u_dut (
      .clk        (clk),
      .reset_n    (reset_n[g]),
      .cmd_valid  (cmd_valid[g]),
      .cmd_ready  (cmd_ready[g]),
      .cmd_ir     (cmd_ir[g]),
      .cmd_data   (cmd_data[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_data   (rsp_data[g]),
      .rsp_ir_out (rsp_ir_out[g]),
      .vji_tck    (vji_tck[g]),
      .vji_tdi    (vji_tdi[g]),
      .vji_tdo    (vji_tdo[g]),
      .vji_ir_in  (vji_ir_in[g]),
      .vji_ir_out (vji_ir_out[g]),
      .vji_rti    (vji_rti[g]),
      .vji_uir    (vji_uir[g]),
      .vji_cdr    (vji_cdr[g]),
      .vji_sdr    (vji_sdr[g]),
      .vji_udr    (vji_udr[g])
    );

    // Behavioural slave: latches IR during UIR, captures at CDR, shifts LSB first
    logic [DW-1:0] sr = '0;
    logic [IW-1:0] ir = '0;
    int            uir_cnt = 0;
    assign vji_tdo[g]    = sr[0];
    assign vji_ir_out[g] = ir ^ 2'b11;
    always @(posedge vji_tck[g]) begin
      if (vji_uir[g]) begin
        ir      <= vji_ir_in[g];
        uir_cnt <= uir_cnt + 1;
      end
      if (vji_cdr[g]) sr <= slv_cap[g];
      if (vji_sdr[g]) sr <= {vji_tdi[g], sr[DW-1:1]};
    end

    // Monitor: measures latency and pops the expected response on each handshake
    int   acc_cyc = 0;
    int   uir_base = 0;
    int   idx;
    logic rv_q = 1'b0;
    always @(negedge clk) begin
      if (cmd_valid[g] && cmd_ready[g]) begin
        acc_cyc  = cyc + 1;
        uir_base = uir_cnt;
      end
      idx = find_exp(g);
      if (rsp_valid[g] && !rv_q) begin
        if (idx < 0) fail_now("unexpected_rsp");
        else chk_range("latency", cyc - acc_cyc, exp_q[idx].lat_min, exp_q[idx].lat_max);
      end
      if (rsp_valid[g] && rsp_ready[g] && idx >= 0) begin
        chk("rsp_data", 64'(rsp_data[g]), 64'(exp_q[idx].data));
        chk("rsp_ir_out", 64'(rsp_ir_out[g]), 64'(exp_q[idx].ir_out));
        chk("slave_rx", 64'(sr), 64'(exp_q[idx].rx));
        chk("uir_pulses", 64'(uir_cnt - uir_base), 64'(exp_q[idx].uir_n));
        exp_q.delete(idx);
      end
      rv_q = rsp_valid[g];
    end
  end

  // Issue one command; optionally push its expected response
  task automatic send(input int u, input logic [IW-1:0] ir, input logic [DW-1:0] data,
                      input logic [DW-1:0] cap, input int lmin, input int lmax,
                      input int nuir, input bit push);
    exp_t e;
    bit   ok = 1'b0;
    if (push) begin
      e.unit = u; e.data = cap; e.ir_out = ir ^ 2'b11; e.rx = data;
      e.lat_min = lmin; e.lat_max = lmax; e.uir_n = nuir;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    slv_cap[u]   = cap;
    cmd_ir[u]    = ir;
    cmd_data[u]  = data;
    cmd_valid[u] = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cmd_ready[u]) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    cmd_valid[u] = 1'b0;
    if (!ok) fail_now("accept_timeout");
  endtask

  task automatic wait_rsp(input int u);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (find_exp(u) < 0) return;
    end
    fail_now("rsp_timeout");
  endtask

  task automatic reset_vals(input int u);
    chk("rst_tck", 64'(vji_tck[u]), 64'(0));
    chk("rst_tdi", 64'(vji_tdi[u]), 64'(0));
    chk("rst_ir_in", 64'(vji_ir_in[u]), 64'(0));
    chk("rst_uir", 64'(vji_uir[u]), 64'(0));
    chk("rst_cdr", 64'(vji_cdr[u]), 64'(0));
    chk("rst_sdr", 64'(vji_sdr[u]), 64'(0));
    chk("rst_udr", 64'(vji_udr[u]), 64'(0));
    chk("rst_rti", 64'(vji_rti[u]), 64'(1));
    chk("rst_cmd_ready", 64'(cmd_ready[u]), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid[u]), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data[u]), 64'(0));
    chk("rst_rsp_ir_out", 64'(rsp_ir_out[u]), 64'(0));
  endtask

  localparam logic [DW-1:0] CAP = 38'h2A_5A5A_5A5A;
  localparam int LMIN = 165;
  localparam int LMAX = 168;

  initial begin
    int   rises;
    int   rv_seen;
    logic prev;
    bit   ok;
    for (int u = 0; u < 2; u++) begin
      cmd_ir[u] = '0; cmd_data[u] = '0; slv_cap[u] = CAP;
    end

    // Reset values, then free-running tck shape for both dividers
    repeat (2) @(posedge clk);
    #1 reset_n = 2'b11;
    @(negedge clk);
    reset_vals(0);
    reset_vals(1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("tck_div2", 64'(vji_tck[0]), 64'((k / 2) % 2));
      chk("tck_div1", 64'(vji_tck[1]), 64'(k % 2));
      if (k == 1) chk("idle_cmd_ready", 64'(cmd_ready[0]), 64'(1));
    end

    // Basic scan with the BREAK IR
    send(0, IR_BREAK, 38'h15_DEAD_BEEF, CAP, LMIN, LMAX, 1, 1'b1);
    wait_rsp(0);

    // Backpressure: response held for 50 clks
    rsp_ready[0] = 1'b0;
    send(0, IR_TRACEMEM, 38'h0A_1234_5678, CAP, LMIN, LMAX, 1, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("bp_rsp_timeout");
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 64'(rsp_valid[0]), 64'(1));
      chk("bp_rsp_data", 64'(rsp_data[0]), 64'(CAP));
      chk("bp_cmd_ready", 64'(cmd_ready[0]), 64'(0));
    end
    @(posedge clk); #1 rsp_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_cmd_ready_after", 64'(cmd_ready[0]), 64'(1));

    // Reset in the middle of SDR: command dropped, no response
    send(0, IR_ENABLE, 38'h3F_FFFF_0000, CAP, 0, 0, 0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (vji_sdr[0]) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("sdr_timeout");
    rises = 0;
    prev  = vji_tck[0];
    for (int i = 0; i < 200 && rises < 10; i++) begin
      @(negedge clk);
      if (vji_tck[0] && !prev) rises++;
      prev = vji_tck[0];
    end
    chk("sdr_rises", 64'(rises), 64'(10));
    @(posedge clk); #1 reset_n[0] = 1'b0;
    @(posedge clk); #1 reset_n[0] = 1'b1;
    @(negedge clk);
    reset_vals(0);
    rv_seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) rv_seen++;
    end
    chk("no_rsp_after_reset", 64'(rv_seen), 64'(0));
    send(0, IR_ENABLE, 38'h3F_FFFF_0000, CAP, LMIN, LMAX, 1, 1'b1);
    wait_rsp(0);

    // Back-to-back scans with the same IR
    send(0, IR_OCIMEM, 38'h01_0203_0405, CAP, LMIN, LMAX, 1, 1'b1);
    send(0, IR_OCIMEM, 38'h3E_FDFC_FBFA, CAP, CACHE ? 161 : LMIN, CACHE ? 164 : LMAX,
         CACHE ? 0 : 1, 1'b1);
    wait_rsp(0);

    // Edge data patterns
    send(0, IR_TRACEMEM, {DW{1'b1}}, {DW{1'b0}}, LMIN, LMAX, 1, 1'b1);
    wait_rsp(0);
    send(0, IR_BREAK, {DW{1'b0}}, {DW{1'b1}}, LMIN, LMAX, 1, 1'b1);
    wait_rsp(0);

    // TCK_DIV=1: tck toggles every clk, 41 periods = 82 clks plus 1..2 align
    send(1, IR_BREAK, 38'h25_5555_AAAA, 38'h1A_C3C3_3C3C, 83, 84, 1, 1'b1);
    wait_rsp(1);
    send(1, IR_ENABLE, 38'h00_0000_0001, 38'h20_0000_0000, 83, 84, 1, 1'b1);
    wait_rsp(1);

    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
